rr_mux4: RTL and testbench



---
 rtl/rr_mux4.sv | 67 ++++++
 tb/tb_rr_mux4.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4.sv
// rr_mux4: four-channel round-robin merge onto one registered stream.
// Output beats carry the source index on {S2,S1} for a matching demux.
module rr_mux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             S1,
  output logic             S2,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0] last_grant;
  logic [1:0] gnt;
  logic [1:0] idx;
  logic       any;
  logic       can_load;
  logic       load;

  // Rotating search: first valid channel after the last winner.
  always_comb begin
    gnt = last_grant;
    any = 1'b0;
    idx = last_grant;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!any && in_valid[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  assign load     = rst_n && can_load && any;

  // One-hot ready only for the winner, and only when the slot can take it.
  always_comb begin
    in_ready = 4'b0000;
    if (load) in_ready = 4'b0001 << gnt;
  end

  // Output slot: load replaces, consume empties, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      Y          <= '0;
      S1         <= 1'b0;
      S2         <= 1'b0;
      last_grant <= 2'd3;
    end else if (load) begin
      out_valid  <= 1'b1;
      Y          <= in_data[int'(gnt)*WIDTH +: WIDTH];
      S1         <= gnt[0];
      S2         <= gnt[1];
      last_grant <= gnt;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: randomized and directed checks against a queue-based model.
// Stimulus predicts beats into a scoreboard; a monitor pops on output.
module tb_rr_mux4;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [3:0]     in_ready;
  logic [W-1:0]   Y;
  logic           S1;
  logic           S2;
  logic           out_valid;
  logic           out_ready;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   ch;
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    mlast = 3;
  bit    mfull = 0;

  rr_mux4 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Y(Y),
    .S1(S1),
    .S2(S2),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: scan channels in rotating order from the last winner.
  task automatic model_step();
    int g;
    bit ld;
    logic [3:0] er;
    beat_t b;
    g  = -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (mlast + k) % 4;
      if (g < 0 && in_valid[c]) g = c;
    end
    ld = (g >= 0) && (!mfull || out_ready);
    er = ld ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(mfull));
    if (ld) begin
      b.d  = in_data[g*W +: W];
      b.ch = 2'(g);
      q.push_back(b);
      mlast = g;
    end
    mfull = ld || (mfull && !out_ready);
  endtask

  task automatic cycle(input logic [3:0] v, input logic [4*W-1:0] d,
                       input logic r);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    model_step();
  endtask

  // Monitor: every presented beat must match the scoreboard head.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got Y=%0h S=%0d expected none",
                 Y, {S2, S1});
      end else begin
        chk("beat", {22'd0, S2, S1, Y}, {22'd0, q[0].ch, q[0].d});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  localparam logic [4*W-1:0] RR = {8'h33, 8'h22, 8'h11, 8'h00};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'($urandom);
    in_data   = {$urandom, $urandom};
    out_ready = 1'($urandom);
    #7;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_y", 32'(Y), 0);
    chk("rst_s", 32'({S2, S1}), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    #1;
    in_valid = 4'b0000;
    rst_n    = 1'b1;

    // all channels valid: 0,1,2,3,0,...
    for (int i = 0; i < 9; i++) cycle(4'b1111, RR, 1'b1);
    cycle(4'b0000, RR, 1'b1);

    // sparse: ch2 alone, then ch1+ch3 (ch3 first)
    cycle(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1);
    cycle(4'b0000, '0, 1'b1);
    cycle(4'b1010, {8'hC3, 8'h00, 8'h1B, 8'h00}, 1'b1);
    cycle(4'b0010, {8'hC3, 8'h00, 8'h1B, 8'h00}, 1'b1);
    cycle(4'b0000, '0, 1'b1);
    cycle(4'b0000, '0, 1'b1);

    // backpressure: ch0 held, ch1 pending
    cycle(4'b0001, {8'h00, 8'h00, 8'h00, 8'h7E}, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(4'b0010, {8'h00, 8'h00, 8'h9D, 8'h00}, 1'b0);
    cycle(4'b0010, {8'h00, 8'h00, 8'h9D, 8'h00}, 1'b1);
    cycle(4'b0000, '0, 1'b1);
    cycle(4'b0000, '0, 1'b1);

    // drain: single ch3 beat, then idle
    cycle(4'b1000, {8'h5A, 8'h00, 8'h00, 8'h00}, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0, 1'b1);
    chk("drain_y_hold", 32'(Y), 32'h5A);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 3) != 0));

    // mid-operation reset while stalled
    cycle(4'b0100, {8'h00, 8'h44, 8'h00, 8'h00}, 1'b0);
    cycle(4'b0000, '0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    q.delete();
    mfull = 0;
    mlast = 3;
    @(negedge clk);
    #1;
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    cycle(4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0}, 1'b1);
    cycle(4'b0000, '0, 1'b1);
    chk("midrst_first_y", 32'(Y), 32'hA0);
    chk("midrst_first_s", 32'({S2, S1}), 0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0, 1'b1);
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
